// File: rtl/mux_pkg.sv
// Shared types for the arbitrated channel multiplexer.
//   mode_e : channel selection policy (forced index or round-robin).
package mux_pkg;

  typedef enum logic {
    MODE_FORCED = 1'b0,
    MODE_RR     = 1'b1
  } mode_e;

endpackage

// File: rtl/arb_mux_if.sv
// Handshake bundle between M upstream channels, the arbiter mux and one downstream sink.
//   mode, s              : selection policy and forced channel index
//   in_valid/in_data     : per-channel offers (channel i at in_data[i*N +: N])
//   in_ready             : per-channel accept strobe (at most one bit set)
//   out_valid/out_ready  : output handshake
//   out_data/out_sel     : registered word and the channel it came from
// master = side that drives the channels and sinks the output; slave = arb_mux.
interface arb_mux_if #(
  parameter int unsigned N = 32,
  parameter int unsigned M = 32
);
  import mux_pkg::*;

  localparam int unsigned SW = $clog2(M);

  mode_e           mode;
  logic [SW-1:0]   s;
  logic [M-1:0]    in_valid;
  logic [M*N-1:0]  in_data;
  logic [M-1:0]    in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    out_data;
  logic [SW-1:0]   out_sel;

  modport master (
    output mode, s, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  mode, s, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

endinterface

// File: rtl/rr_arbiter.sv
// Grant selection for arb_mux. Purely combinational.
//   req         : per-channel requests
//   ptr         : round-robin search start index
//   mode, s     : policy and forced index
//   grant       : one-hot grant (all-zero when nothing granted)
//   grant_idx   : encoded grant index (0 when nothing granted)
//   grant_valid : a channel was granted
module rr_arbiter import mux_pkg::*; #(
  parameter int unsigned M = 32
) (
  input  logic [M-1:0]         req,
  input  logic [$clog2(M)-1:0] ptr,
  input  mode_e                mode,
  input  logic [$clog2(M)-1:0] s,
  output logic [M-1:0]         grant,
  output logic [$clog2(M)-1:0] grant_idx,
  output logic                 grant_valid
);

  localparam int unsigned SW = $clog2(M);

  logic [SW-1:0] cand;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    if (mode == MODE_FORCED) begin
      if (req[s]) begin
        grant[s]    = 1'b1;
        grant_idx   = s;
        grant_valid = 1'b1;
      end
    end else begin
      // M is a power of two, so SW-bit addition wraps the search modulo M.
      for (int unsigned k = 0; k < M; k++) begin
        cand = ptr + SW'(k);
        if (!grant_valid && req[cand]) begin
          grant[cand] = 1'b1;
          grant_idx   = cand;
          grant_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// M:1 arbitrated multiplexer with a single registered output stage.
//   clk, rst : clock and synchronous active-high reset
//   bus      : arb_mux_if slave port (channel offers, grant strobes, output handshake)
// The output register reloads whenever it is empty or being drained, giving full
// throughput with one cycle of latency. N >= 1; M a power of two in 2..64.
module arb_mux import mux_pkg::*; #(
  parameter int unsigned N = 32,
  parameter int unsigned M = 32
) (
  input logic      clk,
  input logic      rst,
  arb_mux_if.slave bus
);

  localparam int unsigned SW = $clog2(M);

  logic [M-1:0]  grant;
  logic [SW-1:0] grant_idx;
  logic          grant_valid;
  logic          load;

  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  out_data_q, out_data_d;
  logic [SW-1:0] out_sel_q, out_sel_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic [N-1:0]  ch_data [M];

  rr_arbiter #(
    .M (M)
  ) u_arb (
    .req         (bus.in_valid),
    .ptr         (ptr_q),
    .mode        (bus.mode),
    .s           (bus.s),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign load = !out_valid_q || bus.out_ready;

  // No channel is accepted while stalled or in reset, so nothing is lost or duplicated.
  assign bus.in_ready = (load && !rst) ? grant : '0;

  always_comb begin
    for (int unsigned i = 0; i < M; i++) begin
      ch_data[i] = bus.in_data[i*N +: N];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (load) begin
      if (grant_valid) begin
        out_valid_d = 1'b1;
        out_data_d  = ch_data[grant_idx];
        out_sel_d   = grant_idx;
        if (bus.mode == MODE_RR) begin
          ptr_d = grant_idx + SW'(1);
        end
      end else begin
        // Empty slot: data/sel keep the last word for observability.
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter N, default 32: data width per channel in bits; SHALL be >= 1.
REQ-002 Parameter M, default 32: channel count; SHALL be a power of two, 2..64.
REQ-003 Parameter SW, default $clog2(M): select width, derived, not overridden.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 mode  input  1  0 = FORCED (channel chosen by s), 1 = ROUND_ROBIN.
REQ-007 s  input  SW  forced channel index; ignored in ROUND_ROBIN.
REQ-008 in_valid  input  M  per-channel data-present flag.
REQ-009 in_data  input  M*N  packed channel data; channel i occupies bits [i*N +: N].
REQ-010 in_ready  output  M  per-channel accept strobe; combinational.
REQ-011 out_valid  output  1  registered output holds a word.
REQ-012 out_ready  input  1  downstream accepts the output word.
REQ-013 out_data  output  N  registered selected word.
REQ-014 out_sel  output  SW  registered index of the channel out_data came from.

Function
REQ-015 Transfer on a channel i SHALL occur on a cycle where in_valid[i] and in_ready[i] are both 1; output transfer where out_valid and out_ready are both 1.
REQ-016 load = !out_valid || out_ready; output register SHALL accept a new word only when load = 1 (single-stage pipeline, full throughput, latency 1 cycle input-to-output).
REQ-017 At most one in_ready bit SHALL be 1 per cycle; in_ready SHALL be all-zero when load = 0.
REQ-018 FORCED: grant = s when in_valid[s] = 1, otherwise no grant; other channels SHALL never be granted.
REQ-019 ROUND_ROBIN: grant = lowest index j, searched ptr, ptr+1, ..., wrapping mod M, with in_valid[j] = 1; no grant if in_valid is all-zero.
REQ-020 On a ROUND_ROBIN transfer from channel j, ptr SHALL become (j+1) mod M; ptr SHALL be unchanged on cycles without a ROUND_ROBIN transfer and in FORCED mode.
REQ-021 On a granted transfer: out_valid <= 1, out_data <= in_data of grant, out_sel <= grant.
REQ-022 When load = 1 and no grant: out_valid <= 0; out_data and out_sel SHALL hold their previous values.
REQ-023 When load = 0: out_valid, out_data, out_sel SHALL hold (stall; no data loss, no duplication).
REQ-024 mode or s changing while out_valid = 1 and stalled SHALL NOT alter the held output; the change takes effect at the next load.
REQ-025 Wrap: grant at index M-1 SHALL set ptr to 0.

Reset
REQ-026 While rst = 1 on a clock edge: out_valid <= 0, out_data <= 0, out_sel <= 0, ptr <= 0.
REQ-027 in_ready SHALL be all-zero during any cycle rst = 1; an in-flight output word SHALL be discarded on reset.

Structure
REQ-028 Shared package mux_pkg SHALL hold the mode enum (MODE_FORCED = 0, MODE_RR = 1).
REQ-029 Grant selection SHALL live in one sub-module rr_arbiter (inputs req, ptr, mode, s; output one-hot grant and encoded index); the data path SHALL be a parameterised N-bit M:1 select in arb_mux.

Verification (bench at N = 8, M = 4)
REQ-030 Reset with out_valid = 1 mid-stall -> next cycle out_valid = 0, out_data = 0, out_sel = 0, ptr = 0.
REQ-031 FORCED, s = 2, in_valid = 4'b1111, in_data ch2 = 8'hA5, out_ready = 1 -> in_ready = 4'b0100; one cycle later out_data = 8'hA5, out_sel = 2.
REQ-032 FORCED, s = 1, in_valid = 4'b1101 -> in_ready = 0, out_valid falls to 0 after one cycle.
REQ-033 ROUND_ROBIN, in_valid = 4'b1111 held, out_ready = 1 for 6 cycles -> out_sel sequence 0,1,2,3,0,1 on consecutive cycles.
REQ-034 ROUND_ROBIN, out_ready = 0 for 3 cycles after first word -> out_data/out_sel held, in_ready = 0; on out_ready = 1 the held word transfers once and the next channel loads the same cycle.
REQ-035 ROUND_ROBIN, ptr = 3, in_valid = 4'b0011 -> grant 0 (wrap), ptr becomes 1, next grant 1.
